riscv_test_sequencer: RTL

Synthesizable run controller for the RISC-V core under test. It holds the core in reset, streams a program image into instruction memory through a valid/ready port, and releases reset. It then monitors the core's data-memory port for a store to the TOHOST address and reports pass, fail or timeout with a cycle count. It replaces ad-hoc testbench sequencing and can also drive the golden core in lockstep.

---
 rtl/riscv_test_sequencer_pkg.sv | 24 ++
 rtl/riscv_test_sequencer_if.sv | 23 ++
 rtl/riscv_test_sequencer_watchdog.sv | 28 ++
 rtl/riscv_test_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_test_sequencer_pkg.sv
// Shared types and constants for the RISC-V test sequencer and its watchdog.
package riscv_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } seq_state_e;

    typedef enum logic [2:0] {
        ST_NONE     = 3'd0,
        ST_PASS     = 3'd1,
        ST_FAIL     = 3'd2,
        ST_TIMEOUT  = 3'd3,
        ST_OVERFLOW = 3'd4,
        ST_MISMATCH = 3'd5
    } test_status_e;

    localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] PASS_CODE      = 32'd1;

endpackage

// File: rtl/riscv_test_sequencer_if.sv
// Program-image load stream: the image source is the master, the sequencer the slave.
interface riscv_test_sequencer_if;

    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );

endinterface

// File: rtl/riscv_test_sequencer_watchdog.sv
// RUN-phase cycle counter: saturates at all-ones, flags the final allowed cycle.
module riscv_run_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_enable,
    output logic [31:0] o_count,
    output logic        o_expired
);

    localparam logic [31:0] LAST_CYC = 32'(TIMEOUT_CYC - 1);

    logic [31:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == LAST_CYC);

endmodule

// File: rtl/riscv_test_sequencer.sv
// Run controller: loads imem, holds/releases core reset, watches for the TOHOST store.
// Optional lockstep compare against a golden core: define RISCV_LOCKSTEP_CMP_EN.
//   state | meaning
//   IDLE  | core in reset, waiting for start
//   LOAD  | accepting program words into imem
//   HOLD  | image loaded, core still in reset for RST_HOLD cycles
//   RUN   | core released, monitoring data-memory stores
//   DONE  | result latched, core back in reset
module riscv_test_sequencer
    import riscv_test_pkg::*;
#(
    parameter int unsigned IMEM_AW     = 16,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned RST_HOLD    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    riscv_test_sequencer_if.slave ld_if,
    output logic                  o_imem_we,
    output logic [IMEM_AW-1:0]    o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_cpu_reset,
    input  logic [31:0]           i_mon_a,
    input  logic [31:0]           i_mon_wd,
    input  logic                  i_mon_we,
`ifdef RISCV_LOCKSTEP_CMP_EN
    input  logic [31:0]           i_gold_a,
    input  logic [31:0]           i_gold_wd,
    input  logic                  i_gold_we,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_status,
    output logic [31:0]           o_tohost_val,
    output logic [31:0]           o_cycle_count
);

    localparam int unsigned      HW      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [IMEM_AW-1:0] IDX_MAX = '1;
    localparam logic [HW-1:0]    HOLD_LD = HW'(RST_HOLD - 1);

    seq_state_e         r_state;
    test_status_e       r_status;
    logic [IMEM_AW-1:0] r_idx;
    logic [HW-1:0]      r_hold_cnt;
    logic               r_ld_ready;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_done;
    logic               r_imem_we;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic [31:0]        r_tohost_val;

    logic        w_start_ok;
    logic        w_hs;
    logic        w_tohost;
    logic        w_mismatch;
    logic        w_expired;
    logic        w_wd_en;
    logic [31:0] w_count;

    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_hs       = ld_if.ld_valid && r_ld_ready;
    assign w_tohost   = i_mon_we && (i_mon_a == TOHOST_ADDR);

`ifdef RISCV_LOCKSTEP_CMP_EN
    // Address/data only matter when a store is actually happening.
    assign w_mismatch = (r_state == S_RUN) &&
                        ((i_mon_we != i_gold_we) ||
                         (i_mon_we && ((i_mon_a != i_gold_a) || (i_mon_wd != i_gold_wd))));
`else
    assign w_mismatch = 1'b0;
`endif

    // A mismatching cycle is not counted, so cycle_count points at it.
    assign w_wd_en = (r_state == S_RUN) && !w_mismatch;

    riscv_run_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_start_ok),
        .i_enable  (w_wd_en),
        .o_count   (w_count),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_status     <= ST_NONE;
            r_idx        <= '0;
            r_hold_cnt   <= '0;
            r_ld_ready   <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_tohost_val <= '0;
        end else begin
            r_done    <= 1'b0;
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= S_LOAD;
                        r_status    <= ST_NONE;
                        r_idx       <= '0;
                        r_ld_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cpu_reset <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_idx;
                        r_imem_wdata <= ld_if.ld_data;
                        if (ld_if.ld_last) begin
                            r_state    <= S_HOLD;
                            r_ld_ready <= 1'b0;
                            r_hold_cnt <= HOLD_LD;
                        end else if (r_idx == IDX_MAX) begin
                            r_state      <= S_DONE;
                            r_ld_ready   <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_status     <= ST_OVERFLOW;
                            r_tohost_val <= '1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_mismatch || w_tohost || w_expired) begin
                        r_state     <= S_DONE;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                    if (w_mismatch) begin
                        r_status     <= ST_MISMATCH;
                        r_tohost_val <= i_mon_wd;
                    end else if (w_tohost) begin
                        r_status     <= (i_mon_wd == PASS_CODE) ? ST_PASS : ST_FAIL;
                        r_tohost_val <= i_mon_wd;
                    end else if (w_expired) begin
                        r_status <= ST_TIMEOUT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ld_if.ld_ready = r_ld_ready;
    assign o_imem_we      = r_imem_we;
    assign o_imem_addr    = r_imem_addr;
    assign o_imem_wdata   = r_imem_wdata;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_status       = r_status;
    assign o_tohost_val   = r_tohost_val;
    assign o_cycle_count  = w_count;

endmodule
